// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result handshake bundle for cla_pipe_adder.
// The producer/consumer side uses the master modport, the adder the slave.
// Optional subtract port exists only when CLA_SUB_EN is defined.
`timescale 1ns/1ps
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CLA_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: WIDTH-bit pipelined carry-lookahead adder, one pipeline
// stage per GROUP-bit lookahead group (NS = WIDTH/GROUP stages), with
// valid/ready handshakes on both sides and whole-pipe stall on backpressure.
// Optional feature macro: CLA_SUB_EN (adds the sub input, A + ~B + 1).
`timescale 1ns/1ps
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NS = WIDTH / GROUP;

    // Flattened lookahead: every carry is a sum of products of the group's
    // generate/propagate terms and the group carry-in, no carry feeds another.
    function automatic logic [GROUP:0] group_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        term = 1'b0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = c0;
            for (int m = 0; m <= i; m++) begin
                c[i+1] = c[i+1] & p[m];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // Control state
    logic [NS-1:0]    vld_q;
    logic [NS-1:0]    vld_d;
    logic             advance;

    // Inter-stage data: operands still to be added, partial sum, group carry
    logic [WIDTH-1:0] opa_q [NS];
    logic [WIDTH-1:0] opb_q [NS];
    logic [WIDTH-1:0] ps_q  [NS];
    logic             cy_q  [NS];

    // Stage inputs (stage 0 from the bus, others from the previous register)
    logic [WIDTH-1:0] st_a  [NS];
    logic [WIDTH-1:0] st_b  [NS];
    logic [WIDTH-1:0] st_s  [NS];
    logic             st_c  [NS];

    // Stage results
    logic [WIDTH-1:0] psum_d [NS];
    logic             cy_d   [NS];

    // Output registers
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    // Operand conditioning at the pipeline entry
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

`ifdef CLA_SUB_EN
    // Subtraction reuses the adder as A + ~B + 1; cin is ignored then.
    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        c_eff = bus.sub ? 1'b1 : bus.cin;
    end
`else
    // Plain addition: B and cin go straight in.
    always_comb begin
        b_eff = bus.b;
        c_eff = bus.cin;
    end
`endif

    // The whole pipe moves together unless a held result blocks the output.
    always_comb begin
        advance = !vld_q[NS-1] || bus.out_ready;
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[NS-1];
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Select what each stage works on this cycle.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            st_a[k] = '0;
            st_b[k] = '0;
            st_s[k] = '0;
            st_c[k] = 1'b0;
        end
        st_a[0] = bus.a;
        st_b[0] = b_eff;
        st_s[0] = '0;
        st_c[0] = c_eff;
        for (int k = 1; k < NS; k++) begin
            st_a[k] = opa_q[k-1];
            st_b[k] = opb_q[k-1];
            st_s[k] = ps_q[k-1];
            st_c[k] = cy_q[k-1];
        end
    end

    // Per-stage group addition; stage k fills sum bits [k*GROUP +: GROUP].
    always_comb begin
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        g     = '0;
        p     = '0;
        c     = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < NS; k++) begin
            g         = st_a[k][k*GROUP +: GROUP] & st_b[k][k*GROUP +: GROUP];
            p         = st_a[k][k*GROUP +: GROUP] ^ st_b[k][k*GROUP +: GROUP];
            c         = group_carries(g, p, st_c[k]);
            psum_d[k] = st_s[k];
            psum_d[k][k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
            cy_d[k]   = c[GROUP];
            // Last iteration is the top group: carry into MSB vs carry out.
            ovf_d     = c[GROUP] ^ c[GROUP-1];
        end
        sum_d  = psum_d[NS-1];
        cout_d = cy_d[NS-1];
    end

    // Valid bits shift one stage per advance; bubbles travel as zeros.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = bus.in_valid;
        for (int k = 1; k < NS; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    // Control and result registers: cleared by reset, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Inter-stage data registers: carry skewed operands and partial sums.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < NS - 1; k++) begin
                opa_q[k] <= st_a[k];
                opb_q[k] <= st_b[k];
                ps_q[k]  <= psum_d[k];
                cy_q[k]  <= cy_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed table, random stream, backpressure and
// mid-flight reset checks for cla_pipe_adder (WIDTH=16, GROUP=4).
`timescale 1ns/1ps
module tb_cla_pipe_adder;
    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NS = W / G;

    logic clk;
    logic rst_n;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   n_taken;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operation the user asked for.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t r;
        int ua, ub, sa, sv, us, ss, c;
        ua = a;
        ub = b;
        sa = $signed(a);
        sv = $signed(b);
        c  = ci;
        if (sb) begin
            us = ua + 65536 - ub;
            ss = sa - sv;
        end else begin
            us = ua + ub + c;
            ss = sa + sv + c;
        end
        r.sum  = us[W-1:0];
        r.cout = us[W];
        r.ovf  = (ss > 32767) || (ss < -32768);
        return r;
    endfunction

    // Scoreboard: sampled mid-cycle, ahead of the edge that completes a transfer.
    always @(negedge clk) begin
        exp_t e;
        logic s;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", bus.sum, e.sum);
                    chk("sb_cout", bus.cout, e.cout);
                    chk("sb_ovf", bus.ovf, e.ovf);
                    n_taken++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
`ifdef CLA_SUB_EN
                s = bus.sub;
`else
                s = 1'b0;
`endif
                exp_q.push_back(model(bus.a, bus.b, bus.cin, s));
            end
        end
    end

    task automatic drive_vec(input vec_t v);
        bus.a   = v.a;
        bus.b   = v.b;
        bus.cin = v.cin;
`ifdef CLA_SUB_EN
        bus.sub = v.sub;
`endif
    endtask

    task automatic drive_rand();
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom_range(0, 1));
`ifdef CLA_SUB_EN
        bus.sub = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic sb, input logic [W-1:0] s, input logic co,
                           input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = ci; v.sub = sb;
        v.sum = s; v.cout = co; v.ovf = ov;
        tbl.push_back(v);
    endtask

    // One isolated transfer: check latency, values and single-cycle result.
    task automatic apply_one(input vec_t v, input int idx);
        int lat;
        bus.out_ready = 1'b1;
        drive_vec(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency[%0d]", idx), lat, NS);
        chk($sformatf("sum[%0d]", idx), bus.sum, v.sum);
        chk($sformatf("cout[%0d]", idx), bus.cout, v.cout);
        chk($sformatf("ovf[%0d]", idx), bus.ovf, v.ovf);
        @(posedge clk); #1;
        chk($sformatf("single_result[%0d]", idx), bus.out_valid, 0);
    endtask

    task automatic stream_test();
        int base;
        base = n_taken;
        bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 32 + NS + 2; cyc++) begin
            if (cyc <= 32) begin
                drive_rand();
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc >= NS && cyc < NS + 32) chk("stream_out_valid", bus.out_valid, 1);
            if (cyc == NS + 32) chk("stream_end_valid", bus.out_valid, 0);
        end
        chk("stream_count", n_taken - base, 32);
    endtask

    task automatic bp_test();
        int           accepted;
        int           base;
        int           stalls;
        logic         fire;
        logic         have_held;
        logic [W-1:0] held;
        accepted  = 0;
        stalls    = 0;
        have_held = 1'b0;
        held      = '0;
        base      = n_taken;
        drive_rand();
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.out_ready = !(cyc >= 4 && cyc < 10);
            @(negedge clk);
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                chk("bp_in_ready_low", bus.in_ready, 0);
                if (have_held) chk("bp_sum_stable", bus.sum, held);
                held      = bus.sum;
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                accepted++;
                if (accepted < 12) drive_rand();
                else bus.in_valid = 1'b0;
            end
            if (accepted >= 12 && exp_q.size() == 0) break;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_stall_cycles", stalls, 6);
        chk("bp_accepted", accepted, 12);
        chk("bp_taken", n_taken - base, 12);
        chk("bp_drained", exp_q.size(), 0);
    endtask

    task automatic reset_test();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_out_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", bus.out_valid, 0);
        chk("rst_async_sum", bus.sum, 0);
        chk("rst_async_cout", bus.cout, 0);
        chk("rst_async_ovf", bus.ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_no_stale_valid", bus.out_valid, 0);
        end
        apply_one(tbl[1], 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n_taken = 0;
        rst_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef CLA_SUB_EN
        bus.sub       = 1'b0;
`endif

        //       a        b        cin   sub   sum      cout  ovf
        add_vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        add_vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        add_vec(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        add_vec(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        add_vec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        add_vec(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        add_vec(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        add_vec(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
        add_vec(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        add_vec(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        add_vec(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_sum", bus.sum, 0);
        chk("reset_cout", bus.cout, 0);
        chk("reset_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", bus.in_ready, 1);

        foreach (tbl[i]) apply_one(tbl[i], i);
        stream_test();
        bp_test();
        reset_test();

        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
